// File: rtl/fir_decim_out_pkg.sv
// fir_pkg: shared width constant, saturation limits and round/shift/clamp requant for FIR output taps
package fir_pkg;
  localparam int IN_GUARD = 4;
  localparam int RQ_W = 32;
  function automatic logic signed [RQ_W-1:0] sat_max(input int dw);
    return (32'sd1 <<< (dw - 1)) - 32'sd1;
  endfunction
  function automatic logic signed [RQ_W-1:0] sat_min(input int dw);
    return -(32'sd1 <<< (dw - 1));
  endfunction
  function automatic logic signed [RQ_W-1:0] round_shift(input logic signed [RQ_W-1:0] x, input int shift);
    return (x + ((shift > 0) ? (32'sd1 <<< (shift - 1)) : 32'sd0)) >>> shift;
  endfunction
  function automatic logic signed [RQ_W-1:0] requant(input logic signed [RQ_W-1:0] x, input int shift, input int dw);
    logic signed [RQ_W-1:0] r;
    r = round_shift(x, shift);
    return r > sat_max(dw) ? sat_max(dw) : r < sat_min(dw) ? sat_min(dw) : r;
  endfunction
  function automatic logic clamped(input logic signed [RQ_W-1:0] x, input int shift, input int dw);
    logic signed [RQ_W-1:0] r;
    r = round_shift(x, shift);
    return r > sat_max(dw) || r < sat_min(dw);
  endfunction
endpackage

// File: rtl/fir_decim_out_if.sv
// fir_decim_out_if: FIR sample input plus valid/ready requantized output bus
interface fir_decim_out_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH = DATA_WIDTH + IN_GUARD
);
  logic signed [IN_WIDTH-1:0] y_in;
  logic y_in_en;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output y_in, y_in_en, out_ready, input out_data, out_valid);
  modport slave (input y_in, y_in_en, out_ready, output out_data, out_valid);
endinterface

// File: rtl/fir_decim_out_sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO with head-of-queue output forced to zero when empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem[rd_q];
  assign count = cnt_q;
  always_comb begin
    wr_d = wr ? wr_q + AW'(1) : wr_q;
    rd_d = rd ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_q] <= din;
  end
endmodule

// File: rtl/fir_decim_out.sv
// fir_decim_out: decimate, requantize and FIFO-buffer FIR output; FIR_DECIM_SAT_CNT_EN adds a saturating clamp counter
module fir_decim_out import fir_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH = DATA_WIDTH + IN_GUARD,
  parameter int DECIM = 2,
  parameter int SHIFT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fir_decim_out_if.slave                bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
`ifdef FIR_DECIM_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [PW-1:0] phase_q, phase_d;
  logic signed [DATA_WIDTH-1:0] stage_q, stage_d, fifo_dout;
  logic stage_v_q, stage_v_d, overflow_q, overflow_d;
  logic keep, pop, full, empty;
  logic signed [RQ_W-1:0] y_ext;
  assign y_ext = RQ_W'(bus.y_in);
  assign keep = bus.y_in_en && phase_q == '0;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    phase_d = !bus.y_in_en ? phase_q : phase_q == PW'(DECIM - 1) ? '0 : phase_q + PW'(1);
    stage_v_d = keep;
    stage_d = keep ? DATA_WIDTH'(requant(y_ext, SHIFT, DATA_WIDTH)) : stage_q;
    overflow_d = overflow_q || (stage_v_q && full && !pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      stage_q <= '0;
      stage_v_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stage_q <= stage_d;
      stage_v_q <= stage_v_d;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(stage_v_q),
    .pop(pop),
    .din(stage_q),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign bus.out_data = fifo_dout;
  assign bus.out_valid = !empty;
  assign overflow = overflow_q;
`ifdef FIR_DECIM_SAT_CNT_EN
  logic [15:0] sat_q, sat_d;
  always_comb begin
    sat_d = (keep && clamped(y_ext, SHIFT, DATA_WIDTH) && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_q <= '0;
    else sat_q <= sat_d;
  end
  assign sat_count = sat_q;
`endif
endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed and random stimulus checked every cycle against a queue-based reference model
module tb_fir_decim_out;
  localparam int DW = 8;
  localparam int IW = 12;
  localparam int DECIM = 2;
  localparam int SHIFT = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] fifo_count;
  logic overflow;
`ifdef FIR_DECIM_SAT_CNT_EN
  logic [15:0] sat_count;
`endif
  int total = 0;
  int bad = 0;
  int n_hs = 0;
  int q[$];
  bit pend_v;
  int pend;
  bit m_ovf;
  int m_sat;
  int nstr;
  fir_decim_out_if #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) bus();
  fir_decim_out #(
    .DATA_WIDTH(DW), .IN_WIDTH(IW), .DECIM(DECIM), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .fifo_count(fifo_count),
    .overflow(overflow)
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    .sat_count(sat_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int ref_rq(input int y, output bit c);
    int v, d, r, hi, lo;
    d = 1 << SHIFT;
    v = y + d / 2;
    r = (v >= 0) ? v / d : -((-v + d - 1) / d);
    hi = (1 << (DW - 1)) - 1;
    lo = -(1 << (DW - 1));
    c = r > hi || r < lo;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
  function automatic void model_reset();
    q.delete();
    pend_v = 0;
    pend = 0;
    m_ovf = 0;
    m_sat = 0;
    nstr = 0;
  endfunction
  function automatic void model_edge(input int y, input bit en, input bit rdy);
    int sz;
    bit pop, c;
    sz = q.size();
    pop = sz > 0 && rdy;
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      if (sz == DEPTH && !pop) m_ovf = 1;
      else q.push_back(pend);
    end
    pend_v = 0;
    if (en) begin
      if (nstr % DECIM == 0) begin
        pend = ref_rq(y, c);
        pend_v = 1;
        if (c && m_sat < 65535) m_sat++;
      end
      nstr++;
    end
  endfunction
  task automatic check_all();
    chk("out_valid", bus.out_valid, q.size() > 0 ? 1 : 0);
    chk("out_data", bus.out_data, q.size() > 0 ? q[0] : 0);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_count", sat_count, m_sat);
`endif
  endtask
  task automatic step(input int y, input bit en, input bit rdy);
    bus.y_in = IW'(y);
    bus.y_in_en = en;
    bus.out_ready = rdy;
    if (rst && bus.out_valid && rdy) n_hs++;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(y, en, rdy);
    #1 check_all();
  endtask
  initial begin
    bus.y_in = '0;
    bus.y_in_en = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #1 check_all();
    for (int i = 0; i < 4; i++) step(int'($urandom_range(0, 4095)) - 2048, 1'b1, 1'b1);
    @(negedge clk) rst = 1'b1;
    step(40, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    chk("round_pos", bus.out_data, 3);
    step(-40, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    chk("round_neg", bus.out_data, -2);
    step(2040, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    chk("sat_hi", bus.out_data, 127);
    step(-2048, 1'b1, 1'b1);
    step(0, 1'b1, 1'b1);
    chk("sat_lo", bus.out_data, -128);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_cnt_one", sat_count, 1);
`endif
    step(0, 1'b0, 1'b1);
    n_hs = 0;
    step(16, 1'b1, 1'b1);
    step(32, 1'b1, 1'b1);
    chk("decim_first", bus.out_data, 1);
    step(48, 1'b1, 1'b1);
    step(64, 1'b1, 1'b1);
    chk("decim_second", bus.out_data, 3);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("decim_outputs", n_hs, 2);
    for (int i = 0; i < 5; i++) begin
      step(16 + 32 * i, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
    end
    chk("bp_count", fifo_count, 4);
    chk("bp_overflow", overflow, 1);
    chk("bp_head", bus.out_data, 1);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1);
    chk("bp_drained", fifo_count, 0);
    chk("bp_ovf_sticky", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      step(16 + 16 * i, 1'b1, 1'b0);
      step(0, 1'b1, 1'b0);
    end
    step(64, 1'b1, 1'b0);
    chk("mid_count", fifo_count, 3);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    chk("mid_rst_count", fifo_count, 0);
    @(negedge clk) rst = 1'b1;
    step(80, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("post_rst_first", bus.out_data, 5);
    for (int i = 0; i < 600; i++)
      step(int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
